seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor with an internal accumulator.
- Operands are WIDTH bits wide. The carry chain is evaluated CHUNK bits per clock, with the carry registered between chunks.
- Successor to the team's fixed 4-bit ripple adder. Adds subtract and accumulate modes, status flags and a valid/ready handshake on both sides.
- Sits between the IO wrapper and downstream datapath logic wherever a long carry chain must not limit the clock period.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per RUN cycle. N = WIDTH/CHUNK cycles per operation; N = 1 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for ACC ops).
- cin  in  1  carry in (ADD and ACC_ADD only).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out. For subtract ops: 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.
- acc  out  WIDTH  accumulator value.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0, acc=0, chunk index=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, latch operands and go to RUN.
  - Operand X = a for ADD/SUB, acc for ACC ops.
  - Operand Y = b (ADD), ~b (SUB), a (ACC_ADD), ~a (ACC_SUB).
  - Initial carry = cin for ADD/ACC_ADD, 1 for SUB/ACC_SUB.
  - Chunk index set to 0.
- RUN:
  - in_ready=0.
  - Each cycle: {c, s} = X[chunk] + Y[chunk] + carry. Write s into sum[chunk] and register c.
  - On the last chunk, also record carry-into-MSB for ovf.
  - After chunk N-1, go to DONE.
  - Chunks are processed LSB first.
  - sum is not valid while in RUN and may change.
- DONE:
  - out_valid=1.
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
  - acc <= sum, loaded on the DONE-entry edge.
  - sum, cout, ovf, zero and acc hold stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE. out_valid drops the next cycle.
- Latency:
  - Request accepted at edge k → out_valid high after edge k+N.
  - Minimum issue interval is N+2 cycles. No overlap of requests.
  - in_valid while in_ready=0 is ignored; no queueing.
- acc updates on every completed op, including ADD and SUB, not only ACC ops.
- Reset mid-operation (RUN or DONE): the operation is abandoned, all registers return to reset values, and no out_valid pulse is produced.
- Wrap-around:
  - Results are modulo 2^WIDTH.
  - The carry beyond the MSB appears only on cout.
- Simultaneous events:
  - rst has priority over all handshakes.
  - in_valid and out_ready asserted together in DONE: only the result is consumed; the request must be re-presented in IDLE.

Test Plan (WIDTH=16, CHUNK=4, N=4):
- ADD a=0xFFFF b=0x0001 cin=0 → sum=0x0000, cout=1, ovf=0, zero=1, acc=0x0000; out_valid exactly 4 cycles after accept.
- ADD a=0x7FFF b=0x0001 → sum=0x8000, cout=0, ovf=1. SUB a=0x8000 b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- SUB a=0x0003 b=0x0005 → sum=0xFFFE, cout=0 (borrow), ovf=0, zero=0.
- Accumulate: ADD 0x1234+0x0000 → acc=0x1234. ACC_ADD a=0x0F0F cin=1 → sum=acc=0x2144. ACC_SUB a=0x2144 → sum=0x0000, zero=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a → outputs frozen, in_ready=0, no new request taken; out_ready=1 → IDLE next cycle.
- Reset: assert rst at the 2nd RUN cycle → next cycle state IDLE, in_ready=1, sum=acc=0, out_valid never pulses. Also rerun the first scenario with CHUNK=16 (N=1) → out_valid 1 cycle after accept.

Source files
------------

// File: rtl/seq_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_addsub : multi-cycle add/sub, CHUNK bits per clock, with accumulator  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [WIDTH-1:0] r_x, r_y, r_sum, r_acc;
  logic             r_carry, r_cout, r_ovf, r_zero;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] w_x_init, w_y_init, w_sum_next;
  logic             w_c_init, w_c, w_cmsb, w_last;
  logic [CHUNK-1:0] w_s;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)        w_state_next = S_RUN;
      S_RUN:   if (r_idx == C_LAST) w_state_next = S_DONE;
      S_DONE:  if (out_ready)       w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  // Operand capture: op[1] selects the accumulator as X, op[0] selects subtract.
  always_comb begin
    w_x_init = op[1] ? r_acc : a;
    w_c_init = op[0] ? 1'b1 : cin;
    case (op)
      2'b00:   w_y_init = b;
      2'b01:   w_y_init = ~b;
      2'b10:   w_y_init = a;
      default: w_y_init = ~a;
    endcase
  end

  // X and Y shift right each RUN cycle so the active chunk is always the low slice.
  assign {w_c, w_s} = {1'b0, r_x[CHUNK-1:0]} + {1'b0, r_y[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};
  assign w_cmsb = w_s[CHUNK-1] ^ r_x[CHUNK-1] ^ r_y[CHUNK-1];
  assign w_last = (r_state == S_RUN) && (r_idx == C_LAST);

  generate
    if (N == 1) begin : g_single
      assign w_sum_next = w_s;
    end else begin : g_multi
      assign w_sum_next = {w_s, r_sum[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= w_x_init;
            r_y     <= w_y_init;
            r_carry <= w_c_init;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_x     <= r_x >> CHUNK;
          r_y     <= r_y >> CHUNK;
          r_carry <= w_c;
          r_sum   <= w_sum_next;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_c;
            r_ovf  <= w_cmsb ^ w_c;
            r_zero <= (w_sum_next == '0);
            r_acc  <= w_sum_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign acc       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_addsub : checks seq_addsub (N=4 and N=1) against arithmetic model  |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, out_ready;
  logic [1:0]  op;
  logic [15:0] a, b;

  logic        rdy4, ov4, co4, of4, z4;
  logic [15:0] sum4, acc4;
  logic        rdy1, ov1, co1, of1, z1;
  logic [15:0] sum1, acc1;

  int tests = 0;
  int fails = 0;
  logic [15:0] macc;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(ov4), .out_ready(out_ready),
    .sum(sum4), .cout(co4), .ovf(of4), .zero(z4), .acc(acc4));

  seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(ov1), .out_ready(out_ready),
    .sum(sum1), .cout(co1), .ovf(of1), .zero(z1), .acc(acc1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the selected operands.
  task automatic model(input logic [1:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                       input logic mcin, input logic [15:0] mac,
                       output logic [15:0] s, output logic co, output logic ov, output logic z);
    logic [15:0] x, y;
    int ux, uy, sx, sy, ci, r, sr;
    x  = mop[1] ? mac : ma;
    y  = mop[1] ? ma  : mb;
    ux = int'(x);
    uy = int'(y);
    sx = $signed(x);
    sy = $signed(y);
    if (!mop[0]) begin
      ci = mcin ? 1 : 0;
      r  = ux + uy + ci;
      sr = sx + sy + ci;
      co = (r > 65535);
    end else begin
      r  = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end
    s  = 16'(r);
    ov = (sr > 32767) || (sr < -32768);
    z  = (s == 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input int hold);
    logic [15:0] es;
    logic eco, eov, ez;
    int lat, lat1;
    model(o, va, vb, vc, macc, es, eco, eov, ez);
    macc = es;
    check("in_ready_before", {31'd0, rdy4}, 32'd1);
    op = o; a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check("in_ready_run", {31'd0, rdy4}, 32'd0);
    lat = 0; lat1 = -1;
    while (!ov4 && lat < 20) begin
      if (lat1 < 0 && ov1) lat1 = lat;
      tick();
      lat++;
    end
    if (lat1 < 0 && ov1) lat1 = lat;
    check("latency_n4", 32'(lat), 32'd4);
    check("latency_n1", 32'(lat1), 32'd1);
    repeat (hold) begin
      in_valid = 1'($urandom);
      a = 16'($urandom);
      tick();
      check("bp_valid", {31'd0, ov4}, 32'd1);
      check("bp_ready", {31'd0, rdy4}, 32'd0);
      check("bp_sum", {16'd0, sum4}, {16'd0, es});
    end
    check("sum4",  {16'd0, sum4}, {16'd0, es});
    check("cout4", {31'd0, co4},  {31'd0, eco});
    check("ovf4",  {31'd0, of4},  {31'd0, eov});
    check("zero4", {31'd0, z4},   {31'd0, ez});
    check("acc4",  {16'd0, acc4}, {16'd0, es});
    check("sum1",  {16'd0, sum1}, {16'd0, es});
    check("flags1", {29'd0, co1, of1, z1}, {29'd0, eco, eov, ez});
    check("acc1",  {16'd0, acc1}, {16'd0, es});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("consumed_valid", {31'd0, ov4}, 32'd0);
    check("consumed_ready", {31'd0, rdy4}, 32'd1);
    if (hold > 0) begin
      tick();
      check("no_request_taken", {31'd0, rdy4}, 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    macc = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_ready", {31'd0, rdy4}, 32'd1);
    check("reset_valid", {31'd0, ov4}, 32'd0);
    check("reset_sum", {16'd0, sum4}, 32'd0);
    check("reset_flags", {29'd0, co4, of4, z4}, 32'd0);
    check("reset_acc", {16'd0, acc4}, 32'd0);

    run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(2'b01, 16'h8000, 16'h0001, 1'b0, 0);
    run_op(2'b01, 16'h0003, 16'h0005, 1'b1, 0);
    run_op(2'b00, 16'h1234, 16'h0000, 1'b0, 0);
    run_op(2'b10, 16'h0F0F, 16'h5555, 1'b1, 0);
    check("acc_add_value", {16'd0, acc4}, 32'h2144);
    run_op(2'b11, 16'h2144, 16'hAAAA, 1'b1, 0);
    check("acc_sub_zero", {31'd0, z4}, 32'd1);
    run_op(2'b00, 16'h4321, 16'h1111, 1'b0, 10);

    // Abandon an operation in its second RUN cycle.
    run_op(2'b00, 16'h0101, 16'h0202, 1'b0, 0);
    op = 2'b00; a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    macc = '0;
    check("midrst_ready", {31'd0, rdy4}, 32'd1);
    check("midrst_sum", {16'd0, sum4}, 32'd0);
    check("midrst_acc", {16'd0, acc4}, 32'd0);
    check("midrst_acc1", {16'd0, acc1}, 32'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (ov4 || ov1) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    for (int i = 0; i < 30; i++)
      run_op(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
